// File: rtl/mul16_ctrl_if.sv
// mul16_ctrl_if: request/response bundle between the ALU front end and the
// sequential multiplier.
//   op_start      start request; operands sampled on the same edge
//   op_clear      synchronous clear/abort, wins over op_start
//   multiplicand  operand A (unsigned, 16 bits)
//   multiplier    operand B (unsigned, 16 bits)
//   result        32-bit product, valid while op_done, otherwise 0
//   op_done       level, high while the product is held
//   busy          high while iterating
// master = front end, slave = multiplier.
interface mul16_ctrl_if;
    logic        op_start;
    logic        op_clear;
    logic [15:0] multiplicand;
    logic [15:0] multiplier;
    logic [31:0] result;
    logic        op_done;
    logic        busy;

    modport master (
        output op_start, op_clear, multiplicand, multiplier,
        input  result, op_done, busy
    );

    modport slave (
        input  op_start, op_clear, multiplicand, multiplier,
        output result, op_done, busy
    );
endinterface

// File: rtl/mul16_ctrl.sv
// mul16_ctrl: sequential 16x16 -> 32 unsigned shift-add multiplier.
// One shared upper-half adder (cla32_16) is stepped over 16 iterations;
// the product is valid 16 clocks after the start edge.
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   bus      mul16_ctrl_if.slave (start/clear, operands, result, op_done, busy)

// 4-bit carry-lookahead block.
module cla4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);
    logic [3:0] g, p;
    logic [3:0] c;

    assign g = a & b;
    assign p = a ^ b;

    assign c[0] = ci;
    assign c[1] = g[0] | (p[0] & ci);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & ci);
    assign co   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & ci);

    assign s = p ^ c;
endmodule

// Upper-half adder: sum[31:16] = a[31:16] + b + ci, sum[15:0] = a[15:0].
// Four cla4 blocks chained on their group carries.
module cla32_16 (
    input  logic [31:0] a,
    input  logic [15:0] b,
    input  logic        ci,
    output logic [31:0] sum,
    output logic        co
);
    localparam int NUM_BLK = 4;

    logic [NUM_BLK:0] c_chain;

    assign c_chain[0] = ci;
    assign sum[15:0]  = a[15:0];
    assign co         = c_chain[NUM_BLK];

    for (genvar i = 0; i < NUM_BLK; i++) begin : g_blk
        cla4 u_cla4 (
            .a  (a[16 + 4*i +: 4]),
            .b  (b[4*i +: 4]),
            .ci (c_chain[i]),
            .s  (sum[16 + 4*i +: 4]),
            .co (c_chain[i+1])
        );
    end
endmodule

module mul16_ctrl (
    input  logic        clk,
    input  logic        reset_n,
    mul16_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t      state;
    logic [31:0] p;
    logic [15:0] m;
    logic [3:0]  cnt;
    logic        busy_q;
    logic        done_q;

    logic [31:0] sum;
    logic        co;

    cla32_16 u_cla (
        .a   (p),
        .b   (m),
        .ci  (1'b0),
        .sum (sum),
        .co  (co)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            p      <= '0;
            m      <= '0;
            cnt    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else if (bus.op_clear) begin
            state  <= IDLE;
            p      <= '0;
            m      <= '0;
            cnt    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    // DONE holds P until a new start; a start there reloads
                    // directly so results can issue back-to-back.
                    if (bus.op_start) begin
                        state  <= EXEC;
                        p      <= {16'h0000, bus.multiplier};
                        m      <= bus.multiplicand;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                        done_q <= 1'b0;
                    end
                end
                EXEC: begin
                    // sum[0] is the pass-through of P[0], the current
                    // multiplier bit; the adder carry becomes the new MSB.
                    if (sum[0])
                        p <= {co, sum[31:1]};
                    else
                        p <= {1'b0, p[31:1]};

                    if (cnt == 4'd15) begin
                        state  <= DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy    = busy_q;
    assign bus.op_done = done_q;
    // Registered select only, so no input-to-output glitch path.
    assign bus.result  = done_q ? p : 32'h0000_0000;
endmodule

// File: tb/tb_mul16_ctrl.sv
// tb_mul16_ctrl: directed + random check of mul16_ctrl against a
// transaction-level model (product = A*B, ready 16 clocks after accept).
module tb_mul16_ctrl;
    logic clk = 1'b0;
    logic reset_n;

    always #5 clk = ~clk;

    mul16_ctrl_if bus ();

    mul16_ctrl dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // Model: accepted op -> busy for 16 edges -> done holding A*B.
    logic        m_busy, m_done;
    int          m_left;
    logic [31:0] m_prod;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_busy <= 1'b0; m_done <= 1'b0; m_left <= 0; m_prod <= '0;
        end else if (bus.op_clear) begin
            m_busy <= 1'b0; m_done <= 1'b0; m_left <= 0; m_prod <= '0;
        end else if (m_busy) begin
            if (m_left == 1) begin
                m_busy <= 1'b0;
                m_done <= 1'b1;
            end
            m_left <= m_left - 1;
        end else if (bus.op_start) begin
            m_busy <= 1'b1;
            m_done <= 1'b0;
            m_left <= 16;
            m_prod <= {16'h0000, bus.multiplicand} * {16'h0000, bus.multiplier};
        end
    end

    // Per-cycle compare against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                n_vec++;
                if (bus.busy !== m_busy || bus.op_done !== m_done ||
                    bus.result !== (m_done ? m_prod : 32'h0)) begin
                    n_err++;
                    $display("FAIL cycle t=%0t: busy=%b done=%b result=%h, want busy=%b done=%b result=%h",
                             $time, bus.busy, bus.op_done, bus.result,
                             m_busy, m_done, (m_done ? m_prod : 32'h0));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", nm, got, exp);
        end
    endtask

    task automatic issue(input logic [15:0] a, input logic [15:0] b);
        bus.op_start     = 1'b1;
        bus.multiplicand = a;
        bus.multiplier   = b;
        tick();
        bus.op_start     = 1'b0;
    endtask

    // Issue, then pin the exact done edge and the product with literals.
    task automatic run_mul(input string nm, input logic [15:0] a, input logic [15:0] b,
                           input logic [31:0] exp);
        int bcnt;
        issue(a, b);
        bcnt = 0;
        for (int i = 0; i < 15; i++) begin
            if (bus.busy === 1'b1) bcnt++;
            tick();
        end
        if (bus.busy === 1'b1) bcnt++;
        chk({nm, " pre_done"}, {31'b0, bus.op_done}, 32'd0);
        chk({nm, " pre_result"}, bus.result, 32'h0);
        tick();
        chk({nm, " busy_cycles"}, bcnt, 32'd16);
        chk({nm, " done"}, {31'b0, bus.op_done}, 32'd1);
        chk({nm, " result"}, bus.result, exp);
    endtask

    task automatic wait_done(input string nm);
        int k;
        k = 0;
        while (bus.op_done !== 1'b1 && k < 40) begin
            tick();
            k++;
        end
        if (bus.op_done !== 1'b1) begin
            n_vec++;
            n_err++;
            $display("FAIL %s timeout: op_done=%b after 40 cycles, want 1", nm, bus.op_done);
        end
    endtask

    initial begin
        logic [15:0] ra, rb;
        reset_n          = 1'b0;
        bus.op_start     = 1'b0;
        bus.op_clear     = 1'b0;
        bus.multiplicand = '0;
        bus.multiplier   = '0;
        tick();
        tick();
        chk("reset busy", {31'b0, bus.busy}, 32'd0);
        chk("reset done", {31'b0, bus.op_done}, 32'd0);
        chk("reset result", bus.result, 32'h0);
        reset_n = 1'b1;
        chk_en  = 1'b1;
        tick();

        run_mul("basic", 16'h0003, 16'h0005, 32'h0000_000F);
        run_mul("b2b", 16'd7, 16'd9, 32'h0000_003F);
        run_mul("ffff", 16'hFFFF, 16'hFFFF, 32'hFFFE_0001);
        run_mul("carry", 16'h8000, 16'h0002, 32'h0001_0000);
        run_mul("zero_b", 16'h1234, 16'h0000, 32'h0000_0000);
        run_mul("zero_a", 16'h0000, 16'hFFFF, 32'h0000_0000);

        // Start pulses during EXEC must be ignored.
        issue(16'h0011, 16'h0022);
        for (int i = 0; i < 15; i++) begin
            if (i == 4 || i == 9) begin
                bus.op_start     = 1'b1;
                bus.multiplicand = 16'hAAAA;
                bus.multiplier   = 16'h5555;
            end
            tick();
            bus.op_start = 1'b0;
        end
        chk("ign pre_done", {31'b0, bus.op_done}, 32'd0);
        tick();
        chk("ign result", bus.result, 32'h0000_0242);

        // Abort at E0+8.
        issue(16'h00FF, 16'h00FF);
        repeat (7) tick();
        bus.op_clear = 1'b1;
        tick();
        bus.op_clear = 1'b0;
        chk("abort busy", {31'b0, bus.busy}, 32'd0);
        chk("abort result", bus.result, 32'h0);
        repeat (12) begin
            tick();
            chk("abort done", {31'b0, bus.op_done}, 32'd0);
        end

        // Async reset at E0+5.
        issue(16'h0101, 16'h0202);
        repeat (4) tick();
        reset_n = 1'b0;
        #1;
        chk("rst busy", {31'b0, bus.busy}, 32'd0);
        chk("rst done", {31'b0, bus.op_done}, 32'd0);
        chk("rst result", bus.result, 32'h0);
        tick();
        reset_n = 1'b1;
        tick();

        // Clear beats start in IDLE.
        bus.op_clear = 1'b1;
        bus.op_start = 1'b1;
        tick();
        bus.op_clear = 1'b0;
        bus.op_start = 1'b0;
        chk("prio busy", {31'b0, bus.busy}, 32'd0);
        tick();
        chk("prio done", {31'b0, bus.op_done}, 32'd0);

        // Random pairs, issued back-to-back from DONE.
        for (int i = 0; i < 1000; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            issue(ra, rb);
            wait_done("rand");
            chk("rand result", bus.result, {16'h0000, ra} * {16'h0000, rb});
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
